// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: synchronises and debounces the car sensor into a clean level, edge pulses and an arrival count
module car_sensor_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor,
  input  logic             clr_cnt,
  output logic             car,
  output logic             arrive,
  output logic             depart,
  output logic [CNT_W-1:0] arrivals
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RISE, PRESENT, FALL} state_t;
  state_t state, state_nx;
  logic s1, s2, arrive_nx, depart_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] arrivals_nx, base;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    arrive_nx = 1'b0;
    depart_nx = 1'b0;
    case (state)
      IDLE: if (s2) begin
        state_nx = RISE;
        cnt_nx = CW'(1);
      end
      RISE: if (!s2) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end else if (cnt == LAST) begin
        state_nx = PRESENT;
        cnt_nx = '0;
        arrive_nx = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      PRESENT: if (!s2) begin
        state_nx = FALL;
        cnt_nx = CW'(1);
      end
      FALL: if (s2) begin
        state_nx = PRESENT;
        cnt_nx = '0;
      end else if (cnt == LAST) begin
        state_nx = IDLE;
        cnt_nx = '0;
        depart_nx = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  // clear takes effect before a coincident arrival is counted
  assign base = clr_cnt ? '0 : arrivals;
  assign arrivals_nx = (arrive_nx && base != '1) ? base + 1'b1 : base;
  assign car = (state == PRESENT) || (state == FALL);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      arrive <= 1'b0;
      depart <= 1'b0;
      arrivals <= '0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
      state <= state_nx;
      cnt <= cnt_nx;
      arrive <= arrive_nx;
      depart <= depart_nx;
      arrivals <= arrivals_nx;
    end
  end
endmodule

// File: tb/tb_car_sensor_conditioner.sv
// tb_car_sensor_conditioner: random and directed stimulus against a run-length model of the debouncer
module tb_car_sensor_conditioner;
  localparam int DEB = 4;
  logic clk = 1'b0, rst = 1'b0, sensor = 1'b0, clr_cnt = 1'b0;
  logic car8, arr8, dep8, car2, arr2, dep2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int vectors = 0, miscompares = 0;
  bit checking = 1'b0;
  // model: sensor delayed two samples, level flips once a run of DEB equal samples disagrees with car
  bit m_s1, m_s2, m_prev, m_car, m_arr, m_dep;
  int m_run, m_c8, m_c2;

  car_sensor_conditioner #(.DEB_CYCLES(DEB)) d8 (
    .clk(clk), .rst(rst), .sensor(sensor), .clr_cnt(clr_cnt),
    .car(car8), .arrive(arr8), .depart(dep8), .arrivals(cnt8));
  car_sensor_conditioner #(.DEB_CYCLES(DEB), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .sensor(sensor), .clr_cnt(clr_cnt),
    .car(car2), .arrive(arr2), .depart(dep2), .arrivals(cnt2));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_car = 0; m_arr = 0; m_dep = 0;
      m_run = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      m_arr = 0; m_dep = 0;
      m_run = (m_s2 == m_prev) ? m_run + 1 : 1;
      m_prev = m_s2;
      if (m_s2 != m_car && m_run >= DEB) begin
        m_car = m_s2; m_arr = m_s2; m_dep = !m_s2;
      end
      if (clr_cnt) begin m_c8 = 0; m_c2 = 0; end
      if (m_arr) begin
        m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
        m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
      end
      m_s2 = m_s1;
      m_s1 = sensor;
    end
  end

  always @(negedge clk) if (checking) begin
    vectors++;
    if (car8 !== m_car || arr8 !== m_arr || dep8 !== m_dep || cnt8 !== 8'(m_c8) ||
        car2 !== m_car || arr2 !== m_arr || dep2 !== m_dep || cnt2 !== 2'(m_c2)) begin
      miscompares++;
      $display("FAIL model t=%0t got car=%b/%b arr=%b/%b dep=%b/%b cnt=%0d/%0d exp car=%b arr=%b dep=%b cnt=%0d/%0d",
               $time, car8, car2, arr8, arr2, dep8, dep2, cnt8, cnt2, m_car, m_arr, m_dep, m_c8, m_c2);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int n);
    sensor = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_car", car8, 0);
    chk("reset_cnt", cnt8, 0);
    rst = 1'b1;
    checking = 1'b1;
    drive(0, 3);
    sensor = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("rise_car", car8, i == 6);
      chk("rise_arrive", arr8, i == 6);
    end
    chk("rise_count", cnt8, 1);
    @(posedge clk); #1;
    chk("arrive_width", arr8, 0);
    @(negedge clk);
    drive(1, 6);
    drive(0, 2);
    drive(1, 1);
    sensor = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("fall_car", car8, i < 6);
      chk("fall_depart", dep8, i == 6);
    end
    @(negedge clk);
    drive(0, 6);
    drive(1, 3);
    drive(0, 1);
    drive(1, 2);
    drive(0, 10);
    chk("bounce_car", car8, 0);
    chk("bounce_count", cnt8, 1);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clear_count", cnt2, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 8);
      chk("sat_count", cnt2, k < 3 ? k : 3);
      drive(0, 8);
    end
    chk("wide_count", cnt8, 5);
    sensor = 1'b1;
    repeat (5) @(negedge clk);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    chk("clr_arrive", arr2, 1);
    chk("clr_arrive_count", cnt2, 1);
    @(negedge clk);
    clr_cnt = 1'b0;
    drive(1, 4);
    #2 rst = 1'b0;
    #1;
    chk("async_car", car8, 0);
    chk("async_count", cnt8, 0);
    chk("async_depart", dep8, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("requal_car", car8, i == 6);
    end
    @(negedge clk);
    drive(0, 8);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_alone", cnt2, 0);
    for (int r = 0; r < 1500; r++) begin
      clr_cnt = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end
    clr_cnt = 1'b0;
    drive(0, 10);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
